// File: rtl/instr_hdr_pkg.sv
// Shared instruction header: op_type class codes used by decode and
// sequencing logic.
package instr_hdr_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_NULL = 5'd0;
  localparam logic [OP_W-1:0] OP_ADD  = 5'd1;
  localparam logic [OP_W-1:0] OP_ADDI = 5'd2;
  localparam logic [OP_W-1:0] OP_ADDW = 5'd3;
  localparam logic [OP_W-1:0] OP_JAL  = 5'd4;
  localparam logic [OP_W-1:0] OP_BEQ  = 5'd5;
  localparam logic [OP_W-1:0] OP_BNE  = 5'd6;
  localparam logic [OP_W-1:0] OP_BLT  = 5'd7;
  localparam logic [OP_W-1:0] OP_LW   = 5'd8;
  localparam logic [OP_W-1:0] OP_SW   = 5'd9;

endpackage

// File: rtl/phase_pkg.sv
// Phase sequencer shared definitions: one-hot phase encoding and the
// bit positions of the per-instruction route mask.
package phase_pkg;

  localparam int PH_FETCH      = 0;
  localparam int PH_DECODE     = 1;
  localparam int PH_EXECUTE    = 2;
  localparam int PH_VISIT_MEM  = 3;
  localparam int PH_WRITE_BACK = 4;

  typedef enum logic [4:0] {
    ST_IDLE       = 5'b00000,
    ST_FETCH      = 5'b00001,
    ST_DECODE     = 5'b00010,
    ST_EXECUTE    = 5'b00100,
    ST_VISIT_MEM  = 5'b01000,
    ST_WRITE_BACK = 5'b10000
  } phase_e;

  localparam int RT_E  = 0;
  localparam int RT_M  = 1;
  localparam int RT_WB = 2;
  localparam int RT_W  = 3;

endpackage

// File: rtl/phase_route.sv
// Combinational op_type to route-mask table (which of E, M, WB an
// instruction visits after DECODE).
module phase_route
  import phase_pkg::*;
  import instr_hdr_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0]  op_type,
  output logic [RT_W-1:0] route
);

  // Route lookup; unknown and NULL classes visit no phase
  always_comb begin
    route = {RT_W{1'b0}};
    case (op_type)
      OPW'(OP_ADD), OPW'(OP_ADDI), OPW'(OP_ADDW), OPW'(OP_JAL): begin
        route[RT_E]  = 1'b1;
        route[RT_WB] = 1'b1;
      end
      OPW'(OP_BEQ), OPW'(OP_BNE), OPW'(OP_BLT): begin
        route[RT_E] = 1'b1;
      end
      OPW'(OP_LW): begin
        route[RT_E]  = 1'b1;
        route[RT_M]  = 1'b1;
        route[RT_WB] = 1'b1;
      end
      OPW'(OP_SW): begin
        route[RT_E] = 1'b1;
        route[RT_M] = 1'b1;
      end
      default: route = {RT_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/phase_seq.sv
// Instruction phase sequencer: walks FETCH..WRITE_BACK per the decoded
// route, bounds memory waits with a timeout, and counts retirements.
module phase_seq
  import phase_pkg::*;
#(
  parameter int OPW   = 5,
  parameter int CNT_W = 32,
  parameter int TMO_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             stall,
  input  logic [OPW-1:0]   op_type,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             fetch,
  output logic             decode,
  output logic             execute,
  output logic             visit_mem,
  output logic             write_back,
  output logic             cyc_done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] instret
);

  // The wait that sees the counter one below the limit is the limit-th waiting cycle
  localparam logic [TMO_W-1:0] WAIT_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  phase_e                state_r;
  logic [RT_WB:RT_M]     route_r;
  logic [RT_W-1:0]       route_s;
  logic [TMO_W-1:0]      wait_r;
  logic [CNT_W-1:0]      instret_r;
  logic                  cyc_done_r;
  logic                  timeout_r;

  phase_route #(.OPW(OPW)) u_route (
    .op_type (op_type),
    .route   (route_s)
  );

  // Sequencer FSM with wait counter, retirement pulse and counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      route_r    <= 2'b00;
      wait_r     <= {TMO_W{1'b0}};
      instret_r  <= {CNT_W{1'b0}};
      cyc_done_r <= 1'b0;
      timeout_r  <= 1'b0;
    end else if (stall) begin
      cyc_done_r <= 1'b0;
    end else begin
      cyc_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (en) begin
            state_r <= ST_FETCH;
            wait_r  <= {TMO_W{1'b0}};
          end
        end
        ST_FETCH: begin
          if (imem_ready) begin
            state_r <= ST_DECODE;
            wait_r  <= {TMO_W{1'b0}};
          end else if (wait_r == WAIT_LAST) begin
            state_r   <= ST_IDLE;
            wait_r    <= {TMO_W{1'b0}};
            timeout_r <= 1'b1;
          end else begin
            wait_r <= wait_r + TMO_W'(1);
          end
        end
        ST_DECODE: begin
          route_r <= route_s[RT_WB:RT_M];
          wait_r  <= {TMO_W{1'b0}};
          state_r <= route_s[RT_E] ? ST_EXECUTE : ST_IDLE;
        end
        ST_EXECUTE: begin
          wait_r <= {TMO_W{1'b0}};
          if (route_r[RT_M]) begin
            state_r <= ST_VISIT_MEM;
          end else if (route_r[RT_WB]) begin
            state_r <= ST_WRITE_BACK;
          end else begin
            state_r    <= ST_IDLE;
            cyc_done_r <= 1'b1;
            instret_r  <= instret_r + CNT_W'(1);
          end
        end
        ST_VISIT_MEM: begin
          if (dmem_ready) begin
            wait_r <= {TMO_W{1'b0}};
            if (route_r[RT_WB]) begin
              state_r <= ST_WRITE_BACK;
            end else begin
              state_r    <= ST_IDLE;
              cyc_done_r <= 1'b1;
              instret_r  <= instret_r + CNT_W'(1);
            end
          end else if (wait_r == WAIT_LAST) begin
            state_r   <= ST_IDLE;
            wait_r    <= {TMO_W{1'b0}};
            timeout_r <= 1'b1;
          end else begin
            wait_r <= wait_r + TMO_W'(1);
          end
        end
        ST_WRITE_BACK: begin
          state_r    <= ST_IDLE;
          wait_r     <= {TMO_W{1'b0}};
          cyc_done_r <= 1'b1;
          instret_r  <= instret_r + CNT_W'(1);
        end
        default: begin
          state_r <= ST_IDLE;
          wait_r  <= {TMO_W{1'b0}};
        end
      endcase
    end
  end

  assign fetch       = state_r[PH_FETCH];
  assign decode      = state_r[PH_DECODE];
  assign execute     = state_r[PH_EXECUTE];
  assign visit_mem   = state_r[PH_VISIT_MEM];
  assign write_back  = state_r[PH_WRITE_BACK];
  assign cyc_done    = cyc_done_r;
  assign timeout_err = timeout_r;
  assign instret     = instret_r;

endmodule

// File: tb/tb_phase_seq.sv
// Self-checking bench for phase_seq: per-instruction expected phase
// sequences built from the routing/wait rules, plus a 4-bit counter copy.
module tb_phase_seq;
  import instr_hdr_pkg::*;

  localparam logic [4:0] S_I = 5'b00000;
  localparam logic [4:0] S_F = 5'b00001;
  localparam logic [4:0] S_D = 5'b00010;
  localparam logic [4:0] S_E = 5'b00100;
  localparam logic [4:0] S_M = 5'b01000;
  localparam logic [4:0] S_W = 5'b10000;

  logic        clk = 1'b0;
  logic        rst, en, stall, imem_ready, dmem_ready;
  logic [4:0]  op_type;
  logic        fetch, decode, execute, visit_mem, write_back, cyc_done, timeout_err;
  logic [31:0] instret;
  logic        d4_fetch, d4_decode, d4_execute, d4_visit_mem, d4_write_back, d4_cyc_done, d4_timeout_err;
  logic [3:0]  d4_instret;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_cnt = 32'd0;
  logic        model_err = 1'b0;

  phase_seq dut (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .op_type(op_type),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .fetch(fetch), .decode(decode), .execute(execute), .visit_mem(visit_mem),
    .write_back(write_back), .cyc_done(cyc_done), .timeout_err(timeout_err),
    .instret(instret)
  );

  phase_seq #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .op_type(op_type),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .fetch(d4_fetch), .decode(d4_decode), .execute(d4_execute), .visit_mem(d4_visit_mem),
    .write_back(d4_write_back), .cyc_done(d4_cyc_done), .timeout_err(d4_timeout_err),
    .instret(d4_instret)
  );

  always #5 clk = ~clk;

  // Route as {WB, M, E} from the instruction-class table
  function automatic logic [2:0] ref_route(input logic [4:0] op);
    if (op inside {OP_ADD, OP_ADDI, OP_ADDW, OP_JAL}) return 3'b101;
    else if (op inside {OP_BEQ, OP_BNE, OP_BLT}) return 3'b001;
    else if (op == OP_LW) return 3'b111;
    else if (op == OP_SW) return 3'b011;
    else return 3'b000;
  endfunction

  // Runs one instruction from IDLE; iw/dw = ready-low cycles in FETCH/VISIT_MEM.
  // Returns the cycle index (from the starting IDLE) where cyc_done was seen, or -1.
  task automatic run_instr(input logic [4:0] op, input int iw, input int dw, output int lat);
    logic [4:0] exp_q[$];
    logic [2:0] rt;
    bit         retire = 1'b0;
    bit         tmo = 1'b0;
    int         fi = 0;
    int         mi = 0;
    int         last;
    logic       exp_done;
    rt = ref_route(op);
    exp_q.push_back(S_I);
    if (iw >= 15) begin
      repeat (15) exp_q.push_back(S_F);
      exp_q.push_back(S_I);
      tmo = 1'b1;
    end else begin
      repeat (iw + 1) exp_q.push_back(S_F);
      exp_q.push_back(S_D);
      if (!rt[0]) begin
        exp_q.push_back(S_I);
      end else begin
        exp_q.push_back(S_E);
        if (rt[1] && dw >= 15) begin
          repeat (15) exp_q.push_back(S_M);
          exp_q.push_back(S_I);
          tmo = 1'b1;
        end else begin
          if (rt[1]) repeat (dw + 1) exp_q.push_back(S_M);
          if (rt[2]) exp_q.push_back(S_W);
          exp_q.push_back(S_I);
          retire = 1'b1;
        end
      end
    end
    last = exp_q.size() - 1;
    lat = -1;
    for (int k = 0; k <= last; k++) begin
      if (k > 0) begin
        if (k == last) begin
          if (retire) model_cnt = model_cnt + 32'd1;
          if (tmo) model_err = 1'b1;
        end
        exp_done = (k == last) && retire;
        if (cyc_done === 1'b1) lat = k;
        checks++;
        if ({write_back, visit_mem, execute, decode, fetch} !== exp_q[k]) begin
          errors++;
          $display("FAIL phase op=%0d k=%0d got=%b exp=%b", op, k,
                   {write_back, visit_mem, execute, decode, fetch}, exp_q[k]);
        end
        checks++;
        if (cyc_done !== exp_done) begin
          errors++;
          $display("FAIL cyc_done op=%0d k=%0d got=%b exp=%b", op, k, cyc_done, exp_done);
        end
        checks++;
        if (instret !== model_cnt) begin
          errors++;
          $display("FAIL instret op=%0d k=%0d got=%0d exp=%0d", op, k, instret, model_cnt);
        end
        checks++;
        if (d4_instret !== model_cnt[3:0]) begin
          errors++;
          $display("FAIL instret4 op=%0d k=%0d got=%0d exp=%0d", op, k, d4_instret, model_cnt[3:0]);
        end
        checks++;
        if (timeout_err !== model_err) begin
          errors++;
          $display("FAIL timeout_err op=%0d k=%0d got=%b exp=%b", op, k, timeout_err, model_err);
        end
      end
      if (k == last) begin
        en = 1'b0;
        break;
      end
      stall = 1'b0;
      en = (k == 0) ? 1'b1 : 1'($urandom);
      op_type = (exp_q[k] == S_D) ? op : 5'($urandom);
      if (exp_q[k] == S_F) begin
        imem_ready = (fi == iw);
        fi++;
      end else begin
        imem_ready = 1'($urandom);
      end
      if (exp_q[k] == S_M) begin
        dmem_ready = (mi == dw);
        mi++;
      end else begin
        dmem_ready = 1'($urandom);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; stall = 1'b1; op_type = OP_ADD;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({write_back, visit_mem, execute, decode, fetch, cyc_done, timeout_err} !== 7'b0 ||
        instret !== 32'd0 || d4_instret !== 4'd0) begin
      errors++;
      $display("FAIL reset got=%b instret=%0d exp=0", {write_back, visit_mem, execute, decode,
               fetch, cyc_done, timeout_err}, instret);
    end
    rst = 1'b1; en = 1'b0; stall = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    int lat;
    run_instr(OP_ADD, 0, 0, lat);
    checks++;
    if (lat != 5 || instret !== 32'd1) begin
      errors++;
      $display("FAIL add_latency got=%0d/%0d exp=5/1", lat, instret);
    end
    run_instr(OP_LW, 0, 3, lat);
    checks++;
    if (lat != 9) begin
      errors++;
      $display("FAIL lw_wait_latency got=%0d exp=9", lat);
    end
    run_instr(OP_SW, 0, 0, lat);
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL sw_latency got=%0d exp=5", lat);
    end
    run_instr(OP_BEQ, 0, 0, lat);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL beq_latency got=%0d exp=4", lat);
    end
    run_instr(OP_LW, 0, 0, lat);
    checks++;
    if (lat != 6) begin
      errors++;
      $display("FAIL lw_latency got=%0d exp=6", lat);
    end
  endtask

  task automatic test_null();
    int lat;
    run_instr(OP_NULL, 1, 0, lat);
    run_instr(5'd31, 0, 0, lat);
    checks++;
    if (lat != -1) begin
      errors++;
      $display("FAIL null_no_retire got=%0d exp=-1", lat);
    end
  endtask

  task automatic test_timeout();
    int lat;
    run_instr(OP_ADD, 14, 0, lat);
    checks++;
    if (timeout_err !== 1'b0 || lat != 19) begin
      errors++;
      $display("FAIL ready_at_limit got=%b/%0d exp=0/19", timeout_err, lat);
    end
    run_instr(OP_ADD, 15, 0, lat);
    checks++;
    if (timeout_err !== 1'b1 || lat != -1) begin
      errors++;
      $display("FAIL fetch_timeout got=%b/%0d exp=1/-1", timeout_err, lat);
    end
    run_instr(OP_SW, 0, 15, lat);
  endtask

  task automatic test_back_to_back();
    logic [4:0] ops[12] = '{OP_NULL, OP_ADD, OP_ADDI, OP_ADDW, OP_JAL, OP_BEQ,
                            OP_BNE, OP_BLT, OP_LW, OP_SW, 5'd17, 5'd10};
    int lat, iw, dw, r;
    for (int n = 0; n < 25; n++) begin
      r = $urandom_range(0, 9);
      iw = (r < 8) ? (r % 3) : ((r == 8) ? 14 : 16);
      r = $urandom_range(0, 9);
      dw = (r < 8) ? (r % 4) : ((r == 8) ? 14 : 15);
      run_instr(ops[$urandom_range(0, 11)], iw, dw, lat);
    end
  endtask

  task automatic test_stall_reset();
    bit rs[11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
    bit st[11] = '{1, 0, 1, 0, 0, 1, 1, 1, 0, 1, 0};
    bit ev[11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    bit dm[11] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
    logic [4:0] ex[11] = '{S_I, S_F, S_F, S_D, S_E, S_E, S_E, S_E, S_M, S_I, S_I};
    for (int r = 0; r < 11; r++) begin
      rst = rs[r]; stall = st[r]; en = ev[r]; imem_ready = 1'b1; dmem_ready = dm[r];
      op_type = (r == 4) ? OP_LW : 5'($urandom);
      @(negedge clk);
      if (r == 9) begin
        model_cnt = 32'd0;
        model_err = 1'b0;
      end
      checks++;
      if ({write_back, visit_mem, execute, decode, fetch} !== ex[r] || cyc_done !== 1'b0) begin
        errors++;
        $display("FAIL stall_reset row=%0d got=%b/%b exp=%b/0", r,
                 {write_back, visit_mem, execute, decode, fetch}, cyc_done, ex[r]);
      end
      checks++;
      if (instret !== model_cnt || timeout_err !== model_err) begin
        errors++;
        $display("FAIL stall_reset_cnt row=%0d got=%0d/%b exp=%0d/%b", r, instret,
                 timeout_err, model_cnt, model_err);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_wrap();
    logic [4:0] rops[4] = '{OP_ADD, OP_LW, OP_SW, OP_BLT};
    logic [3:0] v;
    int lat;
    repeat (3) run_instr(OP_ADDI, 0, 0, lat);
    v = d4_instret;
    for (int n = 0; n < 16; n++) run_instr(rops[$urandom_range(0, 3)], $urandom_range(0, 2),
                                           $urandom_range(0, 2), lat);
    checks++;
    if (d4_instret !== v || v !== 4'd3) begin
      errors++;
      $display("FAIL wrap got=%0d exp=%0d (start 3)", d4_instret, v);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_null();
    test_timeout();
    test_back_to_back();
    test_stall_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/phase_seq.md
PHASE_SEQ -- requirements
Module: phase_seq

Interface
REQ-001 The block SHALL have parameter OPW, default 5, meaning op_type width, matching the shared instruction header.
REQ-002 The block SHALL have parameter CNT_W, default 32, meaning retired-instruction counter width.
REQ-003 The block SHALL have parameter TMO_W, default 4, meaning wait-counter width; timeout limit = 2^TMO_W-1 cycles.
REQ-004 The block SHALL have port clk  input  1  the single clock; all logic on posedge.
REQ-005 The block SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 The block SHALL have port en  input  1  permits leaving IDLE.
REQ-007 The block SHALL have port stall  input  1  freezes all state while high.
REQ-008 The block SHALL have port op_type  input  OPW  decoded instruction class, valid during DECODE.
REQ-009 The block SHALL have port imem_ready  input  1  instruction memory done; checked in FETCH.
REQ-010 The block SHALL have port dmem_ready  input  1  data memory done; checked in VISIT_MEM.
REQ-011 The block SHALL have ports fetch, decode, execute, visit_mem, write_back  output  1 each  one-hot phase strobes; all low in IDLE.
REQ-012 The block SHALL have port cyc_done  output  1  one-cycle pulse on instruction retirement.
REQ-013 The block SHALL have port timeout_err  output  1  sticky memory-wait timeout flag.
REQ-014 The block SHALL have port instret  output  CNT_W  retired-instruction count, wraps modulo 2^CNT_W.

Function
REQ-015 The states SHALL be IDLE, FETCH, DECODE, EXECUTE, VISIT_MEM, WRITE_BACK, encoded one-hot, with IDLE = all zero.
REQ-016 Route per op_type: ADD/ADDI/ADDW/JAL -> E,WB; BEQ/BNE/BLT -> E; LW -> E,M,WB; SW -> E,M; NULL/other -> none.
REQ-017 The route SHALL be latched on the DECODE exit edge; op_type SHALL be ignored in every other state.
REQ-018 IDLE SHALL go to FETCH when en=1 and stall=0; otherwise it SHALL hold.
REQ-019 FETCH SHALL go to DECODE when imem_ready=1; otherwise it SHALL hold and increment the wait counter.
REQ-020 DECODE SHALL go to EXECUTE when the route is non-empty; with an empty route it SHALL go to IDLE with no cyc_done and no instret change.
REQ-021 EXECUTE SHALL go to VISIT_MEM if the route has M, else to WRITE_BACK if the route has WB, else to IDLE (retire).
REQ-022 VISIT_MEM SHALL go to WRITE_BACK or IDLE (retire), per route, when dmem_ready=1; otherwise it SHALL hold and increment the wait counter.
REQ-023 WRITE_BACK SHALL go to IDLE (retire) after exactly one cycle.
REQ-024 stall=1 SHALL freeze state, wait counter, route, and counters; stall SHALL take priority over ready and en.
REQ-025 The wait counter SHALL clear on every state change; on reaching 2^TMO_W-1 with ready still low, the block SHALL go to IDLE, set timeout_err, and not retire.
REQ-026 Ready arriving in the same cycle the counter hits the limit SHALL count as success; no timeout.
REQ-027 cyc_done SHALL be registered, high for exactly the first IDLE cycle after a retiring transition; instret SHALL increment on that same edge.
REQ-028 Minimum latency with ready tied high SHALL be: ALU 5 cycles IDLE-to-IDLE, branch 4, LW 6, SW 5.

Reset
REQ-029 On rst=0 at a clock edge, the block SHALL set state IDLE, all phase strobes 0, cyc_done 0, timeout_err 0, instret 0, wait counter 0, and route 0.
REQ-030 Reset mid-instruction SHALL abandon it without retiring; reset SHALL override stall.

Structure
REQ-031 The shared package phase_pkg SHALL hold the phase one-hot constants and route-mask bit positions (E, M, WB); op_type codes SHALL remain in the existing instruction header.
REQ-032 The op_type-to-route table SHALL be one combinational sub-module, phase_route; the FSM, wait counter, and retirement counter SHALL live in phase_seq.

Verification
REQ-033 The bench SHALL apply reset, en=1, ready=1, op_type=ADD -> fetch, decode, execute, write_back each high one cycle in order; cyc_done at cycle 5; instret=1.
REQ-034 The bench SHALL apply op_type=LW, dmem_ready low 3 cycles -> visit_mem high 4 cycles, then write_back; instret increments once.
REQ-035 The bench SHALL apply op_type=SW, then BEQ -> write_back never asserted; 2 cyc_done pulses, spaced 5 then 4 cycles.
REQ-036 The bench SHALL hold imem_ready=0 with TMO_W=4 -> after 15 FETCH cycles, IDLE, timeout_err=1 sticky, instret unchanged; ready arriving at cycle 15 -> no error.
REQ-037 The bench SHALL assert stall for 3 cycles in EXECUTE, then rst=0 during VISIT_MEM -> phase frozen 3 cycles; after reset all outputs 0, no cyc_done.
REQ-038 The bench SHALL apply op_type=NULL at DECODE, and separately preload instret with CNT_W=4 then 16 retirements -> return to IDLE without pulse; instret wraps to the same value.
